// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling, one-cycle rx_valid strobe.
// Define UART_RX_FRAME_ERR_EN to add the frame_err port and the WAIT_HIGH break-recovery state.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_RX_FRAME_ERR_EN
        ,
        S_WAIT_HIGH
`endif
    } state_t;

    logic        r_rx_meta;
    logic        r_rx_s;
    state_t      r_state;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;

    state_t      w_state_nx;
    logic [15:0] w_timer_nx;
    logic [2:0]  w_bit_idx_nx;
    logic [7:0]  w_shift_nx;
    logic [7:0]  w_rx_data_nx;
    logic        w_rx_valid_nx;

`ifdef UART_RX_FRAME_ERR_EN
    logic        r_frame_err;
    logic        w_frame_err_nx;
`endif

    // Input synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_bit_idx  <= w_bit_idx_nx;
            r_shift    <= w_shift_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_frame_err <= 1'b0;
        else     r_frame_err <= w_frame_err_nx;
    end
`endif

    // Timer is cleared at every sample point, so it is bounded by CLKS_PER_BIT-1.
    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer + 16'd1;
        w_bit_idx_nx  = r_bit_idx;
        w_shift_nx    = r_shift;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        w_frame_err_nx = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_timer_nx   = 16'd0;
                w_bit_idx_nx = 3'd0;
                if (!r_rx_s) w_state_nx = S_START;
            end
            S_START: begin
                if (r_timer == HALF_M1) begin
                    w_timer_nx   = 16'd0;
                    w_bit_idx_nx = 3'd0;
                    w_state_nx   = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_timer == FULL_M1) begin
                    w_timer_nx = 16'd0;
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) w_state_nx = S_STOP;
                    else                   w_bit_idx_nx = r_bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (r_timer == FULL_M1) begin
                    w_timer_nx = 16'd0;
`ifdef UART_RX_FRAME_ERR_EN
                    if (r_rx_s) begin
                        w_rx_data_nx  = r_shift;
                        w_rx_valid_nx = 1'b1;
                        w_state_nx    = S_IDLE;
                    end else begin
                        w_frame_err_nx = 1'b1;
                        w_state_nx     = S_WAIT_HIGH;
                    end
`else
                    w_rx_data_nx  = r_shift;
                    w_rx_valid_nx = 1'b1;
                    w_state_nx    = S_IDLE;
`endif
                end
            end
`ifdef UART_RX_FRAME_ERR_EN
            S_WAIT_HIGH: begin
                w_timer_nx = 16'd0;
                if (r_rx_s) w_state_nx = S_IDLE;
            end
`endif
            default: begin
                w_timer_nx = 16'd0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state != S_IDLE);
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: serial frames are generated here and received bytes
// are matched against a queue of sent bytes, with frame-timing and reset scenarios.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
    int         ferr_cnt = 0;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    int         fall_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic       prev_v = 1'b0;
    logic [7:0] last_byte = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Receive-side monitor: collects every strobed byte with its cycle stamp.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                got_cyc_q.push_back(cyc);
            end
            if (rx_valid && prev_v) chk("valid_2cyc", 1, 0);
`ifdef UART_RX_FRAME_ERR_EN
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
`endif
        end
        prev_v <= rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line-level frame generator; leaves rx at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        fall_q.push_back(cyc);
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop_bit;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        exp_q.push_back(b);
        last_byte = b;
    endtask

    task automatic clear_all();
        exp_q.delete();
        fall_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic compare_frames(input string tag);
        int n;
        int lat;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, int'(got_q[i]), int'(exp_q[i]));
            lat = got_cyc_q[i] - fall_q[i];
            chk({tag, "_latency"}, (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) ? LAT_NOM : lat, LAT_NOM);
        end
        clear_all();
    endtask

    initial begin
        logic [7:0] gprmc [6];
        logic [7:0] b;
        gprmc = '{8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C};

        // Reset state
        idle(4);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef UART_RX_FRAME_ERR_EN
        chk("rst_ferr", int'(frame_err), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // Single '$'
        send_good(8'h24);
        idle(2 * CPB);
        compare_frames("dollar");
        chk("dollar_busy", int'(busy), 0);
        chk("dollar_hold", int'(rx_data), 8'h24);

        // Back-to-back sentence fragment
        foreach (gprmc[i]) send_good(gprmc[i]);
        idle(2 * CPB);
        compare_frames("gprmc");

        // False start
        @(negedge clk);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * CPB);
        chk("false_n", got_q.size(), 0);
        chk("false_data", int'(rx_data), int'(last_byte));
        chk("false_busy", int'(busy), 0);
        clear_all();

        // Bad stop bit with the line held low
        send_byte(8'h41, 1'b0);
        idle(40 - CPB);
        rx = 1'b1;
        idle(20 * CPB);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_pulses", ferr_cnt, 1);
        chk("ferr_no_valid", got_q.size(), 0);
        chk("ferr_data_held", int'(rx_data), int'(last_byte));
`else
        chk("stopbad_has_valid", (got_q.size() >= 1) ? 1 : 0, 1);
        if (got_q.size() >= 1) chk("stopbad_data", int'(got_q[0]), 8'h41);
`endif
        chk("stopbad_busy", int'(busy), 0);
        clear_all();
        send_good(8'h56);
        idle(2 * CPB);
        compare_frames("recover");

        // Reset in the middle of data bit 4 of 0x55
        b = 8'h55;
        @(negedge clk);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = b[4];
        idle(CPB / 2);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        chk("midrst_data", int'(rx_data), 0);
        last_byte = 8'h00;
        @(negedge clk);
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(12 * CPB);
        chk("midrst_no_strobe", got_q.size(), 0);
        chk("midrst_idle", int'(busy), 0);
        clear_all();
        send_good(8'hAA);
        idle(2 * CPB);
        compare_frames("after_rst");

        // Random bytes with random idle gaps (including zero)
        for (int k = 0; k < 10; k++) begin
            send_good(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 40));
        end
        idle(2 * CPB);
        compare_frames("random");
        chk("random_hold", int'(rx_data), int'(last_byte));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=0x%0h want=0x0", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, giving clk cycles per serial bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port rx, input, 1 bit: asynchronous serial line from the GPS module, 8N1, idle high.
REQ-005 The block SHALL have port rx_data, output, 8 bits: last received byte.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: one-cycle strobe qualifying rx_data, consumed by the downstream NMEA sentence parser.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a frame is in progress (any state other than IDLE).
REQ-008 The block SHALL have port frame_err, output, 1 bit, present only when UART_RX_FRAME_ERR_EN is defined: one-cycle strobe on a bad stop bit.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer, reset to 1; all sampling SHALL use the synchronized signal (rx_s).
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP, and with the macro defined, WAIT_HIGH.
REQ-011 IDLE: when rx_s is 0, the FSM SHALL go to START and clear the bit-timer.
REQ-012 START: when the bit-timer reaches CLKS_PER_BIT/2-1 (integer division), the FSM SHALL sample rx_s; 0 -> DATA with timer cleared and bit index 0; 1 -> IDLE (false start, no strobe).
REQ-013 DATA: each time the timer reaches CLKS_PER_BIT-1, the FSM SHALL sample rx_s into the shift register LSB-first and clear the timer; after bit index 7 it SHALL go to STOP.
REQ-014 STOP: when the timer reaches CLKS_PER_BIT-1, the FSM SHALL sample rx_s; on 1 it SHALL load rx_data from the shift register, assert rx_valid for exactly one cycle, and return to IDLE.
REQ-015 The bit-timer SHALL be 16 bits wide and SHALL never wrap: it clears on every sample point and on every state change.
REQ-016 rx_data SHALL hold its value until the next successful frame; it SHALL NOT change on false starts or frame errors.
REQ-017 rx_valid SHALL never be high for 2 consecutive cycles.
REQ-018 Back-to-back frames with zero idle time SHALL be received: IDLE detects the next start bit on the cycle after the STOP return.
REQ-019 Latency: rx_valid SHALL rise 2 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT cycles (+/-1) after the rx falling edge.
REQ-020 No downstream back-pressure exists; every strobed byte is final.

Reset
REQ-021 While rst is high, the block SHALL hold state IDLE, timer 0, bit index 0, shift register 0x00, rx_data 0x00, rx_valid 0, busy 0, frame_err 0, and synchronizer flops 1.
REQ-022 rst asserted mid-frame SHALL abort the frame with no strobe; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-023 Macro UART_RX_FRAME_ERR_EN defined: frame_err SHALL exist; a stop-bit sample of 0 SHALL pulse frame_err for one cycle, suppress rx_valid, leave rx_data unchanged, and enter WAIT_HIGH. WAIT_HIGH SHALL go to IDLE on the first cycle rx_s is 1 (break tolerance).
REQ-024 Macro undefined: no frame_err port and no WAIT_HIGH state; the stop-bit value SHALL be ignored, with the byte loaded and rx_valid strobed as for a good stop bit.

Verification (CLKS_PER_BIT=16)
REQ-025 Send 0x24 ('$'), 8N1 -> rx_data=0x24, single rx_valid pulse about 154 cycles after the falling edge; busy low afterwards.
REQ-026 Send "GPRMC," back-to-back with no idle gap -> six pulses carrying 0x47,0x50,0x52,0x4D,0x43,0x2C in order.
REQ-027 Drive rx low for 4 cycles, then high -> no rx_valid, rx_data unchanged, FSM back in IDLE.
REQ-028 Send 0x41 with stop bit 0, line held low 40 cycles -> with macro: frame_err pulse, no rx_valid, recovery on a following 0x56; without macro: rx_valid with rx_data=0x41.
REQ-029 Assert rst during data bit 4 of 0x55 -> all outputs reset immediately, no strobe; the next byte 0xAA is received correctly.
